pmem_responder: RTL and testbench

- Physical-memory side of the line-transfer protocol driven by the cache arbiter.
- Accepts one 128-bit line read or write per request on pmem_read/pmem_write, with a 16-bit byte address.
- Applies a programmable access delay, then moves the line as 8 sequential 16-bit beats to or from a word-wide synchronous SRAM.
- Pulses pmem_resp for one cycle on completion; this is the memory model/controller behind the arbiter.

---
 rtl/pmem_responder_pkg.sv | 20 ++
 rtl/pmem_responder_if.sv | 38 +++
 rtl/pmem_responder_line_shift_reg.sv | 47 ++++
 rtl/pmem_responder.sv | 139 +++++++++++++
 tb/tb_pmem_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the physical-memory responder.
//   lc3b_line      : 128-bit cache line, word i = bits [16i+15:16i]
//   lc3b_word      : 16-bit SRAM word
//   lc3b_line_addr : line address (byte address bits [15:4])
//   beat_idx_t     : index of a 16-bit beat within a line
package pmem_responder_pkg;

    localparam int unsigned LINE_BEATS = 8;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_word;
    typedef logic [11:0]  lc3b_line_addr;
    typedef logic [2:0]   beat_idx_t;

    // SRAM word address of one beat of a line.
    function automatic logic [14:0] sram_word_addr(lc3b_line_addr line_addr, beat_idx_t beat);
        return {line_addr, beat};
    endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// Line-transfer bus between the cache arbiter and the responder, plus the
// word-wide SRAM port the responder drives.
//   pmem_read/pmem_write : level requests, held until pmem_resp
//   pmem_address         : byte address, bits [3:0] ignored
//   pmem_wdata/rdata     : 128-bit lines
//   pmem_resp            : one-cycle completion pulse
//   sram_*               : synchronous SRAM, read data valid one cycle after sram_re
// master: arbiter / SRAM side.  slave: the responder.
interface pmem_responder_if;
    import pmem_responder_pkg::*;

    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    lc3b_line    pmem_wdata;
    lc3b_line    pmem_rdata;
    logic        pmem_resp;
    logic [14:0] sram_addr;
    logic        sram_re;
    logic        sram_we;
    lc3b_word    sram_wdata;
    lc3b_word    sram_rdata;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        input  sram_addr, sram_re, sram_we, sram_wdata,
        output sram_rdata
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        output sram_addr, sram_re, sram_we, sram_wdata,
        input  sram_rdata
    );

endinterface

// File: rtl/pmem_responder_line_shift_reg.sv
// Line storage for the responder.
//   Write side: whole line loaded at request acceptance, one word selected per beat.
//   Read side : line assembled one word at a time from SRAM read data.
// Ports:
//   clk, reset_n              : clock, async active-low reset
//   i_wline_load, i_wline     : load the write line
//   i_wsel, o_wword           : word select of the write line
//   i_rword_we, i_rword_idx,
//   i_rword                   : per-word load into the read line
//   o_rline                   : assembled read line
module pmem_responder_line_shift_reg
    import pmem_responder_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      i_wline_load,
    input  lc3b_line  i_wline,
    input  beat_idx_t i_wsel,
    output lc3b_word  o_wword,
    input  logic      i_rword_we,
    input  beat_idx_t i_rword_idx,
    input  lc3b_word  i_rword,
    output lc3b_line  o_rline
);

    lc3b_line r_wline;
    lc3b_line r_rline;

    // Separate read line so a write never disturbs the last line returned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wline <= '0;
            r_rline <= '0;
        end else begin
            if (i_wline_load) begin
                r_wline <= i_wline;
            end
            if (i_rword_we) begin
                r_rline[{i_rword_idx, 4'b0000} +: 16] <= i_rword;
            end
        end
    end

    assign o_wword = r_wline[{i_wsel, 4'b0000} +: 16];
    assign o_rline = r_rline;

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: accepts one 128-bit line read or write, waits
// DELAY cycles, then moves the line as BEATS 16-bit beats to/from SRAM and
// pulses pmem_resp once.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : line bus + SRAM port (slave modport)
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int unsigned DELAY = 4,
    parameter int unsigned BEATS = LINE_BEATS
) (
    input logic             clk,
    input logic             reset_n,
    pmem_responder_if.slave bus
);

    localparam int unsigned DLY_W     = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam beat_idx_t   LAST_BEAT = beat_idx_t'(BEATS - 1);

    typedef enum logic [2:0] {StIdle, StWait, StXfer, StDrain, StResp} state_t;

    state_t           r_state, w_state_d;
    logic [DLY_W-1:0] r_dly, w_dly_d;
    beat_idx_t        r_beat, w_beat_d;
    lc3b_line_addr    r_line_addr;
    logic             r_is_write;
    logic             r_cap_valid;
    beat_idx_t        r_cap_idx;

    logic        w_accept;
    logic        w_sram_re;
    logic        w_sram_we;
    logic        w_resp;
    logic [14:0] w_sram_addr;
    lc3b_word    w_sram_wdata;
    lc3b_word    w_wword;
    lc3b_line    w_rline;
    logic        w_unused_addr_lo;

    assign w_unused_addr_lo = ^bus.pmem_address[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_dly       <= '0;
            r_beat      <= '0;
            r_line_addr <= '0;
            r_is_write  <= 1'b0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_dly       <= w_dly_d;
            r_beat      <= w_beat_d;
            // Read data for the beat issued now arrives next cycle.
            r_cap_valid <= w_sram_re;
            r_cap_idx   <= r_beat;
            if (w_accept) begin
                r_line_addr <= bus.pmem_address[15:4];
                r_is_write  <= bus.pmem_write;  // write wins if both are high
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_dly_d      = r_dly;
        w_beat_d     = r_beat;
        w_accept     = 1'b0;
        w_sram_re    = 1'b0;
        w_sram_we    = 1'b0;
        w_sram_addr  = '0;
        w_sram_wdata = '0;
        w_resp       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.pmem_read || bus.pmem_write) begin
                    w_accept  = 1'b1;
                    w_dly_d   = '0;
                    w_beat_d  = '0;
                    w_state_d = (DELAY > 0) ? StWait : StXfer;
                end
            end
            StWait: begin
                if (r_dly == DLY_W'(DELAY - 1)) begin
                    w_dly_d   = '0;
                    w_state_d = StXfer;
                end else begin
                    w_dly_d = r_dly + 1'b1;
                end
            end
            StXfer: begin
                w_sram_addr = sram_word_addr(r_line_addr, r_beat);
                w_sram_we   = r_is_write;
                w_sram_re   = !r_is_write;
                if (r_is_write) begin
                    w_sram_wdata = w_wword;
                end
                w_beat_d = r_beat + 1'b1;  // wraps to 0 after the last beat
                if (r_beat == LAST_BEAT) begin
                    w_state_d = r_is_write ? StResp : StDrain;
                end
            end
            StDrain: begin
                w_state_d = StResp;
            end
            StResp: begin
                w_resp    = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    pmem_responder_line_shift_reg u_line (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_wline_load(w_accept),
        .i_wline     (bus.pmem_wdata),
        .i_wsel      (r_beat),
        .o_wword     (w_wword),
        .i_rword_we  (r_cap_valid),
        .i_rword_idx (r_cap_idx),
        .i_rword     (bus.sram_rdata),
        .o_rline     (w_rline)
    );

    assign bus.sram_re    = w_sram_re;
    assign bus.sram_we    = w_sram_we;
    assign bus.sram_addr  = w_sram_addr;
    assign bus.sram_wdata = w_sram_wdata;
    assign bus.pmem_resp  = w_resp;
    assign bus.pmem_rdata = w_rline;

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder (DELAY=4 instance u_dut0 with a
// scoreboard, DELAY=0 instance u_dut1 with direct timing checks).
module tb_pmem_responder;
    import pmem_responder_pkg::*;

    typedef struct packed {
        logic [1:0]  kind;  // 1 write beat, 2 read beat, 3 resp, 0 both strobes
        logic [31:0] cyc;
        logic [14:0] addr;
        lc3b_line    data;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    int unsigned cyc = 0;

    pmem_responder_if b0 ();
    pmem_responder_if b1 ();

    pmem_responder #(.DELAY(4)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    pmem_responder #(.DELAY(0)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models, one-cycle read latency.
    bit [15:0] mem0 [32768];
    bit [15:0] mem1 [32768];
    always @(posedge clk) begin
        if (b0.sram_we) mem0[b0.sram_addr] <= b0.sram_wdata;
        if (b0.sram_re) b0.sram_rdata <= mem0[b0.sram_addr];
        if (b1.sram_we) mem1[b1.sram_addr] <= b1.sram_wdata;
        if (b1.sram_re) b1.sram_rdata <= mem1[b1.sram_addr];
    end

    // Observed events of u_dut0.
    ev_t obs [512];
    int  obs_wr = 0;
    always @(negedge clk) begin
        if (b0.sram_we || b0.sram_re) begin
            obs[obs_wr] <= '{kind: (b0.sram_we && b0.sram_re) ? 2'd0 : (b0.sram_we ? 2'd1 : 2'd2),
                             cyc: cyc, addr: b0.sram_addr,
                             data: b0.sram_we ? {112'b0, b0.sram_wdata} : '0};
            obs_wr <= obs_wr + 1;
        end else if (b0.pmem_resp) begin
            obs[obs_wr] <= '{kind: 2'd3, cyc: cyc, addr: '0, data: b0.pmem_rdata};
            obs_wr <= obs_wr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int obs_rd = 0;
    ev_t exp_q [$];
    lc3b_line line_model [lc3b_line_addr];
    lc3b_line exp_rdata = '0;

    // Expected beats and response of one u_dut0 transaction accepted in cycle t.
    task automatic push_xfer(input int unsigned t, input bit wr, input lc3b_line_addr la,
                             input lc3b_line wl);
        ev_t e;
        for (int i = 0; i < 8; i++) begin
            e.kind = wr ? 2'd1 : 2'd2;
            e.cyc  = t + 5 + i;
            e.addr = {la, 3'(i)};
            e.data = wr ? {112'b0, wl[16*i +: 16]} : '0;
            exp_q.push_back(e);
        end
        if (wr) line_model[la] = wl;
        else exp_rdata = line_model.exists(la) ? line_model[la] : '0;
        e.kind = 2'd3;
        e.cyc  = wr ? t + 13 : t + 14;
        e.addr = '0;
        e.data = exp_rdata;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        int unsigned t;
        bit done;
        ev_t e, o;
        @(negedge clk);
        checks++;
        if ({b0.pmem_resp, b0.sram_re, b0.sram_we, b0.sram_addr, b0.sram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_ctl0 got %h required 0",
                     {b0.pmem_resp, b0.sram_re, b0.sram_we, b0.sram_addr, b0.sram_wdata});
        end
        checks++;
        if (b0.pmem_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata0 got %h required 0", b0.pmem_rdata);
        end
        checks++;
        if ({b1.pmem_resp, b1.sram_re, b1.sram_we, b1.sram_addr, b1.pmem_rdata} !== '0) begin
            errors++; $display("FAIL reset_dut1 got nonzero outputs required 0");
        end
        reset_n = 1'b1;
        // Read accepted, then reset mid-WAIT with the request still held.
        @(negedge clk);
        t = cyc;
        b0.pmem_read = 1'b1;
        b0.pmem_address = 16'h4560;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({b0.pmem_resp, b0.sram_re, b0.sram_we, b0.sram_addr, b0.sram_wdata, b0.pmem_rdata}
            !== '0) begin
            errors++; $display("FAIL reset_mid_wait outputs not 0 (resp=%b re=%b we=%b)",
                               b0.pmem_resp, b0.sram_re, b0.sram_we);
        end
        @(negedge clk);
        reset_n = 1'b1;
        t = cyc;  // request re-accepted at the end of this cycle
        push_xfer(t, 1'b0, 12'h456, '0);
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!done) begin
                @(negedge clk);
                if (b0.pmem_resp) begin done = 1'b1; b0.pmem_read = 1'b0; end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL reset_reaccept resp timeout got none required 1"); end
        b0.pmem_read = 1'b0;
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++; $display("FAIL reset_seq missing event required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL reset_seq got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                             o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            errors++; $display("FAIL reset_extra got %0d extra events required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_write_read();
        lc3b_line wl;
        int unsigned t;
        bit done;
        ev_t e, o;
        logic [15:0] addrs [3];
        addrs[0] = 16'h1230; addrs[1] = 16'h1230; addrs[2] = 16'h123E;
        for (int i = 0; i < 8; i++) wl[16*i +: 16] = 16'(i);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            t = cyc;
            b0.pmem_write = (n == 0);
            b0.pmem_read = (n != 0);
            b0.pmem_address = addrs[n];
            b0.pmem_wdata = wl;
            push_xfer(t, n == 0, 12'h123, wl);
            @(negedge clk);
            // Changes after acceptance must be ignored.
            b0.pmem_address = 16'hFFF0;
            b0.pmem_wdata = '1;
            done = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (!done) begin
                    @(negedge clk);
                    if (b0.pmem_resp) begin done = 1'b1; b0.pmem_read = 1'b0; b0.pmem_write = 1'b0; end
                end
            end
            checks++;
            if (!done) begin errors++; $display("FAIL wr_rd_timeout txn %0d got no resp", n); end
            b0.pmem_read = 1'b0;
            b0.pmem_write = 1'b0;
            repeat (3) @(negedge clk);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++; $display("FAIL wr_rd_seq missing event required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL wr_rd_seq got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                             o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            errors++; $display("FAIL wr_rd_extra got %0d extra events required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_back_to_back();
        lc3b_line wl;
        int unsigned t;
        bit done;
        ev_t e, o;
        wl = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        t = cyc;
        b0.pmem_write = 1'b1;
        b0.pmem_address = 16'h2470;
        b0.pmem_wdata = wl;
        push_xfer(t, 1'b1, 12'h247, wl);  // write resp must still show the previous read line
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!done) begin
                @(negedge clk);
                if (b0.pmem_resp) begin
                    done = 1'b1;
                    // Arbiter switches to the instruction-side read right at resp.
                    b0.pmem_write = 1'b0;
                    b0.pmem_read = 1'b1;
                    b0.pmem_address = 16'h2478;
                    push_xfer(cyc + 1, 1'b0, 12'h247, '0);
                end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL b2b_write_timeout got no resp"); end
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!done) begin
                @(negedge clk);
                if (b0.pmem_resp) begin done = 1'b1; b0.pmem_read = 1'b0; end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL b2b_read_timeout got no resp"); end
        b0.pmem_read = 1'b0;
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++; $display("FAIL b2b_seq missing event required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL b2b_seq got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                             o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            errors++; $display("FAIL b2b_extra got %0d extra events required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_both_high();
        lc3b_line wl;
        int unsigned t;
        bit done;
        ev_t e, o;
        wl = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        t = cyc;
        b0.pmem_write = 1'b1;
        b0.pmem_read = 1'b1;
        b0.pmem_address = 16'h0040;
        b0.pmem_wdata = wl;
        push_xfer(t, 1'b1, 12'h004, wl);
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!done) begin
                @(negedge clk);
                if (b0.pmem_resp) begin done = 1'b1; b0.pmem_read = 1'b0; b0.pmem_write = 1'b0; end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL both_high_timeout got no resp"); end
        repeat (3) @(negedge clk);
        // Read of the same line with the request dropped mid-transfer.
        t = cyc;
        b0.pmem_read = 1'b1;
        push_xfer(t, 1'b0, 12'h004, '0);
        repeat (7) @(negedge clk);
        b0.pmem_read = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!done) begin
                @(negedge clk);
                if (b0.pmem_resp) done = 1'b1;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL drop_read_timeout got no resp"); end
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_wr) begin
                errors++; $display("FAIL both_seq missing event required kind=%0d cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obs[obs_rd]; obs_rd++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL both_seq got k=%0d c=%0d a=%h d=%h required k=%0d c=%0d a=%h d=%h",
                             o.kind, o.cyc, o.addr, o.data, e.kind, e.cyc, e.addr, e.data);
                end
            end
        end
        checks++;
        if (obs_rd != obs_wr) begin
            errors++; $display("FAIL both_extra got %0d extra events required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_zero_delay();
        lc3b_line wl;
        int unsigned t, first, rc;
        bit done;
        wl = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            t = cyc;
            b1.pmem_write = (n == 0);
            b1.pmem_read = (n == 1);
            b1.pmem_address = 16'h3000;
            b1.pmem_wdata = wl;
            first = 32'hFFFF_FFFF;
            rc = 32'hFFFF_FFFF;
            done = 1'b0;
            for (int k = 0; k < 30; k++) begin
                if (!done) begin
                    @(negedge clk);
                    if ((b1.sram_we || b1.sram_re) && first == 32'hFFFF_FFFF) first = cyc;
                    if (b1.pmem_resp) begin
                        rc = cyc; done = 1'b1; b1.pmem_write = 1'b0; b1.pmem_read = 1'b0;
                    end
                end
            end
            checks++;
            if (first !== t + 1) begin
                errors++; $display("FAIL zd_first_beat txn %0d got %0d required %0d", n, first, t + 1);
            end
            checks++;
            if (rc !== t + 9 + n) begin
                errors++; $display("FAIL zd_resp txn %0d got %0d required %0d", n, rc, t + 9 + n);
            end
            if (n == 1) begin
                checks++;
                if (b1.pmem_rdata !== wl) begin
                    errors++; $display("FAIL zd_rdata got %h required %h", b1.pmem_rdata, wl);
                end
            end
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        b0.pmem_read = 1'b0; b0.pmem_write = 1'b0; b0.pmem_address = '0; b0.pmem_wdata = '0;
        b1.pmem_read = 1'b0; b1.pmem_write = 1'b0; b1.pmem_address = '0; b1.pmem_wdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_both_high();
        test_zero_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
